// File: rtl/wfg_spi_arbiter.sv
// Two-requester packet arbiter feeding the SPI drive AXI-stream slave, with a programmable idle gap.
// Optional per-grant word limit enabled by defining WFG_SPI_ARB_MAXBURST_EN (uses MAX_BURST).
module wfg_spi_arbiter #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int MAX_BURST       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       s0_axis_tready_o,
    input  logic                       s0_axis_tvalid_i,
    input  logic                       s0_axis_tlast_i,
    input  logic [AXIS_DATA_WIDTH-1:0] s0_axis_tdata_i,
    output logic                       s1_axis_tready_o,
    input  logic                       s1_axis_tvalid_i,
    input  logic                       s1_axis_tlast_i,
    input  logic [AXIS_DATA_WIDTH-1:0] s1_axis_tdata_i,
    input  logic                       m_axis_tready_i,
    output logic                       m_axis_tvalid_o,
    output logic                       m_axis_tlast_o,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata_o,
    input  logic                       ctrl_en_q_i,
    input  logic                       cfg_prio_q_i,
    input  logic [7:0]                 cfg_gap_q_i,
    output logic [1:0]                 arb_grant_o,
    output logic                       arb_busy_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_t;

    // The burst counter is 8 bits wide, so the limit must fit in it.
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("MAX_BURST must be within 1..255");
    end

    state_t     state_q;
    logic [1:0] grant_q;
    logic       last_served_q;
    logic [7:0] gap_cnt_q;
    logic       src_last;
    logic       handshake;
    logic       pkt_end;
    logic       win_s1;

`ifdef WFG_SPI_ARB_MAXBURST_EN
    logic [7:0] word_cnt_q;
    logic       burst_hit;
`endif

    always_comb begin
        m_axis_tvalid_o = 1'b0;
        m_axis_tdata_o  = '0;
        src_last        = 1'b0;
        if (grant_q[0]) begin
            m_axis_tvalid_o = s0_axis_tvalid_i;
            src_last        = s0_axis_tlast_i;
            m_axis_tdata_o  = s0_axis_tvalid_i ? s0_axis_tdata_i : '0;
        end else if (grant_q[1]) begin
            m_axis_tvalid_o = s1_axis_tvalid_i;
            src_last        = s1_axis_tlast_i;
            m_axis_tdata_o  = s1_axis_tvalid_i ? s1_axis_tdata_i : '0;
        end
    end

`ifdef WFG_SPI_ARB_MAXBURST_EN
    assign burst_hit      = m_axis_tvalid_o && (word_cnt_q == 8'(MAX_BURST - 1));
    assign m_axis_tlast_o = src_last | burst_hit;
`else
    assign m_axis_tlast_o = src_last;
`endif

    assign s0_axis_tready_o = grant_q[0] & m_axis_tready_i;
    assign s1_axis_tready_o = grant_q[1] & m_axis_tready_i;
    assign handshake        = m_axis_tvalid_o & m_axis_tready_i;
    assign pkt_end          = handshake & m_axis_tlast_o;

    // s1 wins if alone, or on a round-robin tie when s0 was served last.
    assign win_s1 = s1_axis_tvalid_i &
                    (~s0_axis_tvalid_i | (~cfg_prio_q_i & ~last_served_q));

    assign arb_grant_o = grant_q;
    assign arb_busy_o  = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= 2'b00;
            last_served_q <= 1'b1;
            gap_cnt_q     <= 8'd0;
`ifdef WFG_SPI_ARB_MAXBURST_EN
            word_cnt_q    <= 8'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctrl_en_q_i && (s0_axis_tvalid_i || s1_axis_tvalid_i)) begin
                        grant_q       <= win_s1 ? 2'b10 : 2'b01;
                        last_served_q <= win_s1;
                        state_q       <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
`ifdef WFG_SPI_ARB_MAXBURST_EN
                    if (handshake) begin
                        word_cnt_q <= word_cnt_q + 8'd1;
                    end
`endif
                    if (pkt_end) begin
                        grant_q <= 2'b00;
`ifdef WFG_SPI_ARB_MAXBURST_EN
                        word_cnt_q <= 8'd0;
`endif
                        if (cfg_gap_q_i == 8'd0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            gap_cnt_q <= cfg_gap_q_i;
                            state_q   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    gap_cnt_q <= gap_cnt_q - 8'd1;
                    if (gap_cnt_q == 8'd1) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wfg_spi_arbiter.sv
// Directed bench for wfg_spi_arbiter: queue-driven requesters plus an expected-beat scoreboard.
module tb_wfg_spi_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } word_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [1:0]  grant;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s0_tready, s1_tready;
    logic        s0_tvalid = 1'b0, s0_tlast = 1'b0;
    logic [31:0] s0_tdata = '0;
    logic        s1_tvalid = 1'b0, s1_tlast = 1'b0;
    logic [31:0] s1_tdata = '0;
    logic        m_tready = 1'b0;
    logic        m_tvalid, m_tlast;
    logic [31:0] m_tdata;
    logic        ctrl_en = 1'b0, cfg_prio = 1'b0;
    logic [7:0]  cfg_gap = 8'd0;
    logic [1:0]  arb_grant;
    logic        arb_busy;

    word_t q0[$];
    word_t q1[$];
    exp_t  exp_q[$];
    int    tests = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    wfg_spi_arbiter #(.AXIS_DATA_WIDTH(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_axis_tready_o(s0_tready), .s0_axis_tvalid_i(s0_tvalid),
        .s0_axis_tlast_i(s0_tlast), .s0_axis_tdata_i(s0_tdata),
        .s1_axis_tready_o(s1_tready), .s1_axis_tvalid_i(s1_tvalid),
        .s1_axis_tlast_i(s1_tlast), .s1_axis_tdata_i(s1_tdata),
        .m_axis_tready_i(m_tready), .m_axis_tvalid_o(m_tvalid),
        .m_axis_tlast_o(m_tlast), .m_axis_tdata_o(m_tdata),
        .ctrl_en_q_i(ctrl_en), .cfg_prio_q_i(cfg_prio), .cfg_gap_q_i(cfg_gap),
        .arb_grant_o(arb_grant), .arb_busy_o(arb_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        tests++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic send(input int src, input logic [31:0] data, input logic last);
        word_t w;
        w.data = data;
        w.last = last;
        if (src == 0) q0.push_back(w);
        else          q1.push_back(w);
    endtask

    task automatic expect_beat(input logic [31:0] data, input logic last, input logic [1:0] grant);
        exp_t e;
        e.data  = data;
        e.last  = last;
        e.grant = grant;
        exp_q.push_back(e);
    endtask

    // Returns at negedge+1 once no more than n expected beats remain outstanding.
    task automatic wait_exp(input int n, input int budget);
        int c = 0;
        while (exp_q.size() > n && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("drain_within_budget", 32'(exp_q.size() <= n), 32'd1);
    endtask

    // Requester models and output monitor: judge handshakes on the stable negedge view,
    // then update requester outputs just after the active edge.
    initial begin
        exp_t  e;
        word_t w;
        forever begin
            @(negedge clk);
            if (rst_n && m_tvalid && m_tready) begin
                if (s0_tready && q0.size() > 0)      w = q0.pop_front();
                else if (s1_tready && q1.size() > 0) w = q1.pop_front();
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] beat data=%0h last=%0b grant=%b", m_tdata, m_tlast, arb_grant);
                    chk("beat_data", m_tdata, e.data);
                    chk("beat_last", 32'(m_tlast), 32'(e.last));
                    chk("beat_grant", 32'(arb_grant), 32'(e.grant));
                    chk("other_tready", 32'(arb_grant[0] ? s1_tready : s0_tready), 32'd0);
                end
            end
            @(posedge clk);
            #1;
            s0_tvalid = (q0.size() != 0);
            s0_tdata  = s0_tvalid ? q0[0].data : '0;
            s0_tlast  = s0_tvalid ? q0[0].last : 1'b0;
            s1_tvalid = (q1.size() != 0);
            s1_tdata  = s1_tvalid ? q1[0].data : '0;
            s1_tlast  = s1_tvalid ? q1[0].last : 1'b0;
        end
    end

    initial begin
        int cnt;
        int guard;
        logic any;

        m_tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(arb_grant), 32'd0);
        chk("rst_busy", 32'(arb_busy), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_s0_tready", 32'(s0_tready), 32'd0);
        chk("rst_s1_tready", 32'(s1_tready), 32'd0);
        rst_n   = 1'b1;
        ctrl_en = 1'b1;

        // Single 3-word packet from s0.
        @(negedge clk);
        #1;
        send(0, 32'hA1, 1'b0); send(0, 32'hA2, 1'b0); send(0, 32'hA3, 1'b1);
        expect_beat(32'hA1, 1'b0, 2'b01);
        expect_beat(32'hA2, 1'b0, 2'b01);
        expect_beat(32'hA3, 1'b1, 2'b01);
        @(negedge clk);
        chk("t1_no_grant_yet", 32'(arb_grant), 32'd0);
        @(negedge clk);
        chk("t1_grant_s0", 32'(arb_grant), 32'd1);
        wait_exp(0, 50);
        @(negedge clk);
        chk("t1_idle_grant", 32'(arb_grant), 32'd0);
        chk("t1_idle_busy", 32'(arb_busy), 32'd0);

        // Round robin, both requesting: s0 was served last, so s1 leads.
        #1;
        for (int i = 0; i < 3; i++) begin
            send(0, 32'hB0 + 32'(i), 1'b1);
            send(1, 32'hC0 + 32'(i), 1'b1);
            expect_beat(32'hC0 + 32'(i), 1'b1, 2'b10);
            expect_beat(32'hB0 + 32'(i), 1'b1, 2'b01);
        end
        wait_exp(0, 100);

        // Fixed priority: s0 keeps winning while it has data.
        @(negedge clk);
        #1;
        cfg_prio = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(0, 32'h30 + 32'(i), 1'b1);
            send(1, 32'h40 + 32'(i), 1'b1);
        end
        for (int i = 0; i < 3; i++) expect_beat(32'h30 + 32'(i), 1'b1, 2'b01);
        for (int i = 0; i < 3; i++) expect_beat(32'h40 + 32'(i), 1'b1, 2'b10);
        wait_exp(0, 100);
        cfg_prio = 1'b0;

        // Gap of 5 between two single-word packets from s0.
        @(negedge clk);
        #1;
        cfg_gap = 8'd5;
        send(0, 32'h50, 1'b1); send(0, 32'h51, 1'b1);
        expect_beat(32'h50, 1'b1, 2'b01);
        expect_beat(32'h51, 1'b1, 2'b01);
        wait_exp(1, 50);
        cnt = 0;
        guard = 0;
        do begin
            @(negedge clk);
            if (arb_grant == 2'b00 && arb_busy && !m_tvalid) cnt++;
            guard++;
        end while (arb_grant == 2'b00 && guard < 40);
        chk("gap_cycles", 32'(cnt), 32'd5);
        wait_exp(0, 50);
        repeat (8) @(negedge clk);
        #1;
        cfg_gap = 8'd0;

        // Enable dropped after the first of four words: packet completes, no new grant.
        send(0, 32'h60, 1'b0); send(0, 32'h61, 1'b0);
        send(0, 32'h62, 1'b0); send(0, 32'h63, 1'b1);
        for (int i = 0; i < 4; i++) expect_beat(32'h60 + 32'(i), i == 3, 2'b01);
        wait_exp(3, 50);
        ctrl_en = 1'b0;
        send(1, 32'h70, 1'b1);
        wait_exp(0, 50);
        any = 1'b0;
        repeat (8) begin
            @(negedge clk);
            any = any | (|arb_grant) | arb_busy;
        end
        chk("en_low_no_grant", 32'(any), 32'd0);
        chk("en_low_s1_waiting", 32'(s1_tvalid), 32'd1);
        #1;
        expect_beat(32'h70, 1'b1, 2'b10);
        ctrl_en = 1'b1;
        wait_exp(0, 50);

        // Reset in the middle of a packet drops it.
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            send(0, 32'h80 + 32'(i), i == 3);
            expect_beat(32'h80 + 32'(i), i == 3, 2'b01);
        end
        wait_exp(2, 50);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_grant", 32'(arb_grant), 32'd0);
        chk("midrst_busy", 32'(arb_busy), 32'd0);
        chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
        exp_q.delete();
        q0.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Six-word s0 packet with s1 pending; last_served is s1 after reset, so s0 leads.
        @(negedge clk);
        #1;
        for (int i = 0; i < 6; i++) send(0, 32'h90 + 32'(i), i == 5);
        send(1, 32'hE0, 1'b1);
`ifdef WFG_SPI_ARB_MAXBURST_EN
        for (int i = 0; i < 4; i++) expect_beat(32'h90 + 32'(i), i == 3, 2'b01);
        expect_beat(32'hE0, 1'b1, 2'b10);
        expect_beat(32'h94, 1'b0, 2'b01);
        expect_beat(32'h95, 1'b1, 2'b01);
`else
        for (int i = 0; i < 6; i++) expect_beat(32'h90 + 32'(i), i == 5, 2'b01);
        expect_beat(32'hE0, 1'b1, 2'b10);
`endif
        wait_exp(0, 100);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
